// File: rtl/cp0_core.sv
// cp0_core: MIPS CP0 subset (BadVAddr/Count/Compare/Status/Cause/EPC) with MTC0/MFC0 port, interrupt/exception/ERET commit and flush redirect
module cp0_core #(
  parameter int          HW_INT_NUM = 6,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter int          COUNT_DIV  = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [4:0]            reg_addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  input  logic [HW_INT_NUM-1:0] hw_int,
  input  logic                  stall,
  input  logic                  exc_valid,
  input  logic [4:0]            exc_code,
  input  logic [31:0]           exc_pc,
  input  logic                  exc_bd,
  input  logic                  exc_badv_we,
  input  logic [31:0]           exc_badvaddr,
  input  logic                  eret,
  output logic                  flush,
  output logic [31:0]           flush_pc,
  output logic                  int_pending,
  output logic                  timer_int
);
  logic [31:0] badvaddr, count, compare, epc, status, cause, rd;
  logic [7:0] im, ip;
  logic [5:0] ip_hw, hw_ext;
  logic [1:0] ip_sw;
  logic [4:0] exc_code_q;
  logic exl, ie, bd, ti, phase;
  logic take_int, take_exc, take_eret, trap, wr, tick, inc;
  assign hw_ext = 6'(hw_int);
  assign ip = {ip_hw[5] | ti, ip_hw[4:0], ip_sw};
  assign status = {9'b0, 1'b1, 6'b0, im, 6'b0, exl, ie};
  assign cause = {bd, ti, 14'b0, ip, 1'b0, exc_code_q, 2'b0};
  assign int_pending = !reset && (|(ip & im)) && ie && !exl;
  assign take_int = !stall && int_pending;
  assign take_exc = !reset && !stall && !int_pending && exc_valid;
  assign take_eret = !reset && !stall && !int_pending && !exc_valid && eret;
  assign trap = take_int || take_exc;
  assign wr = !reset && wr_en && !stall && !trap;
  assign tick = (COUNT_DIV == 1) || phase;
  assign inc = tick && !(wr && reg_addr == 5'd9);
  assign flush = trap || take_eret;
  assign flush_pc = trap ? EXC_VECTOR : take_eret ? epc : 32'h0;
  assign timer_int = ti;
  assign rdata = reset ? 32'h0 : rd;
  always_comb begin
    rd = reg_addr == 5'd8  ? badvaddr :
         reg_addr == 5'd9  ? count :
         reg_addr == 5'd11 ? compare :
         reg_addr == 5'd12 ? status :
         reg_addr == 5'd13 ? cause :
         reg_addr == 5'd14 ? epc : 32'h0;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      badvaddr <= '0;
      count <= '0;
      compare <= '0;
      epc <= '0;
      im <= '0;
      exl <= 1'b0;
      ie <= 1'b0;
      bd <= 1'b0;
      ti <= 1'b0;
      ip_hw <= '0;
      ip_sw <= '0;
      exc_code_q <= '0;
      phase <= 1'b0;
    end else begin
      ip_hw <= hw_ext;
      phase <= (wr && reg_addr == 5'd9) ? 1'b0 : !tick;
      count <= (wr && reg_addr == 5'd9) ? wdata : count + 32'(tick);
      ti <= (wr && reg_addr == 5'd11) ? 1'b0 : (inc && count + 32'd1 == compare) ? 1'b1 : ti;
      exl <= trap ? 1'b1 : take_eret ? 1'b0 : (wr && reg_addr == 5'd12) ? wdata[1] : exl;
      if (wr && reg_addr == 5'd11) compare <= wdata;
      if (wr && reg_addr == 5'd12) begin
        im <= wdata[15:8];
        ie <= wdata[0];
      end
      if (wr && reg_addr == 5'd13) ip_sw <= wdata[9:8];
      if (trap) begin
        exc_code_q <= take_exc ? exc_code : 5'd0;
        if (!exl) begin
          epc <= exc_pc;
          bd <= exc_bd;
        end
      end else if (wr && reg_addr == 5'd14) epc <= wdata;
      if (take_exc && exc_badv_we) badvaddr <= exc_badvaddr;
    end
  end
endmodule

// File: tb/tb_cp0_core.sv
// tb_cp0_core: directed-vector bench for cp0_core (default build plus a HW_INT_NUM=2, COUNT_DIV=1 build)
module tb_cp0_core;
  logic clock = 1'b0;
  logic reset, wr_en, stall, exc_valid, exc_bd, exc_badv_we, eret;
  logic [4:0] reg_addr, exc_code;
  logic [31:0] wdata, exc_pc, exc_badvaddr;
  logic [5:0] hw_int;
  logic [1:0] hw_int2;
  logic [31:0] rdata, flush_pc, rdata2, flush_pc2;
  logic flush, int_pending, timer_int, flush2, int_pending2, timer_int2;
  int vecs = 0, errs = 0;
  always #5 clock = ~clock;
  cp0_core u_dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .reg_addr(reg_addr), .wdata(wdata), .rdata(rdata),
    .hw_int(hw_int), .stall(stall), .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
    .exc_bd(exc_bd), .exc_badv_we(exc_badv_we), .exc_badvaddr(exc_badvaddr), .eret(eret),
    .flush(flush), .flush_pc(flush_pc), .int_pending(int_pending), .timer_int(timer_int)
  );
  cp0_core #(.HW_INT_NUM(2), .COUNT_DIV(1)) u_dut2 (
    .clock(clock), .reset(reset), .wr_en(wr_en), .reg_addr(reg_addr), .wdata(wdata), .rdata(rdata2),
    .hw_int(hw_int2), .stall(stall), .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
    .exc_bd(exc_bd), .exc_badv_we(exc_badv_we), .exc_badvaddr(exc_badvaddr), .eret(eret),
    .flush(flush2), .flush_pc(flush_pc2), .int_pending(int_pending2), .timer_int(timer_int2)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clock);
    #1;
  endtask
  task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    reg_addr = a;
    #1;
    chk(tag, rdata, exp);
  endtask
  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1;
    reg_addr = a;
    wdata = d;
    step;
    wr_en = 1'b0;
  endtask
  initial begin
    reset = 1'b1; wr_en = 1'b0; stall = 1'b0; eret = 1'b0; reg_addr = 5'd12; wdata = '0;
    exc_valid = 1'b1; exc_code = 5'd4; exc_pc = 32'h40; exc_bd = 1'b0; exc_badv_we = 1'b1;
    exc_badvaddr = 32'h55; hw_int = '0; hw_int2 = '0;
    #1;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_flush", {31'b0, flush}, 32'h0);
    chk("rst_flush_pc", flush_pc, 32'h0);
    step; step;
    reset = 1'b0; exc_valid = 1'b0; exc_badv_we = 1'b0;
    rd_chk("rst_status", 5'd12, 32'h00400000);
    rd_chk("rst_cause", 5'd13, 32'h0);
    rd_chk("rst_badv", 5'd8, 32'h0);
    rd_chk("unmapped", 5'd3, 32'h0);
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd0);
    mtc0(5'd12, 32'h00008001);
    exc_pc = 32'h100;
    repeat (8) step;
    chk("ti_early", {31'b0, timer_int}, 32'h0);
    rd_chk("count_4", 5'd9, 32'd4);
    step;
    chk("ti_rise", {31'b0, timer_int}, 32'h1);
    rd_chk("count_5", 5'd9, 32'd5);
    chk("tint_pend", {31'b0, int_pending}, 32'h1);
    chk("tint_flush", {31'b0, flush}, 32'h1);
    chk("tint_fpc", flush_pc, 32'hBFC00380);
    step;
    rd_chk("tint_status", 5'd12, 32'h00408003);
    rd_chk("tint_cause", 5'd13, 32'h40008000);
    rd_chk("tint_epc", 5'd14, 32'h100);
    chk("tint_flush_off", {31'b0, flush}, 32'h0);
    mtc0(5'd11, 32'hFFFF0000);
    chk("ti_clear", {31'b0, timer_int}, 32'h0);
    rd_chk("ti_clear_cause", 5'd13, 32'h0);
    mtc0(5'd12, 32'h0);
    exc_valid = 1'b1; exc_code = 5'h04; exc_bd = 1'b1; exc_pc = 32'hBFC01004;
    exc_badv_we = 1'b1; exc_badvaddr = 32'h3;
    #1;
    chk("exc_flush", {31'b0, flush}, 32'h1);
    chk("exc_fpc", flush_pc, 32'hBFC00380);
    step;
    exc_code = 5'h05; exc_bd = 1'b0; exc_pc = 32'h1234; exc_badv_we = 1'b0;
    rd_chk("exc_epc", 5'd14, 32'hBFC01004);
    rd_chk("exc_cause", 5'd13, 32'h80000010);
    rd_chk("exc_badv", 5'd8, 32'h3);
    rd_chk("exc_status", 5'd12, 32'h00400002);
    step;
    exc_valid = 1'b0;
    rd_chk("nest_epc", 5'd14, 32'hBFC01004);
    rd_chk("nest_cause", 5'd13, 32'h80000014);
    rd_chk("nest_badv", 5'd8, 32'h3);
    eret = 1'b1;
    #1;
    chk("eret_flush", {31'b0, flush}, 32'h1);
    chk("eret_fpc", flush_pc, 32'hBFC01004);
    step;
    eret = 1'b0;
    rd_chk("eret_status", 5'd12, 32'h00400000);
    chk("idle_fpc", flush_pc, 32'h0);
    eret = 1'b1;
    mtc0(5'd12, 32'h00008003);
    eret = 1'b0;
    rd_chk("eret_mtc0", 5'd12, 32'h00408001);
    hw_int = 6'b000001;
    mtc0(5'd12, 32'h00000401);
    chk("hw_pend", {31'b0, int_pending}, 32'h1);
    stall = 1'b1; exc_valid = 1'b1; exc_code = 5'h04; exc_pc = 32'h2000;
    wr_en = 1'b1; reg_addr = 5'd14; wdata = 32'hDEAD;
    #1;
    chk("stall_flush", {31'b0, flush}, 32'h0);
    chk("stall_fpc", flush_pc, 32'h0);
    step;
    wr_en = 1'b0;
    rd_chk("stall_epc", 5'd14, 32'hBFC01004);
    rd_chk("stall_cause", 5'd13, 32'h80000414);
    rd_chk("stall_status", 5'd12, 32'h00400401);
    stall = 1'b0; wr_en = 1'b1; reg_addr = 5'd14;
    #1;
    chk("prio_flush", {31'b0, flush}, 32'h1);
    chk("prio_fpc", flush_pc, 32'hBFC00380);
    step;
    wr_en = 1'b0;
    rd_chk("prio_epc", 5'd14, 32'h2000);
    rd_chk("prio_cause", 5'd13, 32'h00000400);
    rd_chk("prio_status", 5'd12, 32'h00400403);
    exc_badv_we = 1'b1; exc_badvaddr = 32'h77; reset = 1'b1; reg_addr = 5'd14;
    #1;
    chk("rst_mid_rdata", rdata, 32'h0);
    chk("rst_mid_flush", {31'b0, flush}, 32'h0);
    chk("rst_mid_pend", {31'b0, int_pending}, 32'h0);
    step;
    reset = 1'b0; exc_valid = 1'b0; exc_badv_we = 1'b0; hw_int = '0; hw_int2 = 2'b11;
    rd_chk("rst2_epc", 5'd14, 32'h0);
    rd_chk("rst2_cause", 5'd13, 32'h0);
    rd_chk("rst2_status", 5'd12, 32'h00400000);
    rd_chk("rst2_badv", 5'd8, 32'h0);
    rd_chk("rst2_count", 5'd9, 32'h0);
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'hFFFFFFFF);
    #1;
    chk("wrap_pre", rdata2, 32'hFFFFFFFF);
    step;
    chk("wrap_div1", rdata2, 32'h0);
    chk("wrap_div2_hold", rdata, 32'hFFFFFFFF);
    reg_addr = 5'd13;
    #1;
    chk("hw2_cause", rdata2, 32'h00000C00);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/cp0_core.md
CP0_CORE -- requirements
Module: cp0_core

Interface
REQ-001 SHALL have parameter HW_INT_NUM, default 6, number of hardware interrupt lines (legal 1..6).
REQ-002 SHALL have parameter EXC_VECTOR, default 32'hBFC00380, exception/interrupt entry PC.
REQ-003 SHALL have parameter COUNT_DIV, default 2, clock cycles per Count increment (legal 1 or 2).
REQ-004 SHALL have ports `clock` (in, 1, sole clock) and `reset` (in, 1); `reset` is synchronous and active-high.
REQ-005 SHALL have ports:
- wr_en (in, 1): MTC0 strobe.
- reg_addr (in, 5): CP0 register number for read and write.
- wdata (in, 32): MTC0 data.
- rdata (out, 32): MFC0 data.
REQ-006 SHALL have ports:
- hw_int (in, HW_INT_NUM): level-sensitive external interrupts.
- stall (in, 1): pipeline stalled, so no commit.
REQ-007 SHALL have ports:
- exc_valid (in, 1), exc_code (in, 5): resolved exception and its ExcCode.
- exc_pc (in, 32): exact PC of the oldest uncommitted instruction, supplied every cycle.
- exc_bd (in, 1): that instruction is in a delay slot.
REQ-008 SHALL have ports:
- exc_badv_we (in, 1), exc_badvaddr (in, 32): BadVAddr update and its value.
- eret (in, 1): ERET commit.
REQ-009 SHALL have outputs:
- flush (out, 1), flush_pc (out, 32): redirect request and its target.
- int_pending (out, 1): interrupt would be taken.
- timer_int (out, 1): Cause.TI.

Function
REQ-010 SHALL implement these registers:
- BadVAddr (8), Count (9), Compare (11), Status (12), Cause (13), EPC (14).
- Any other reg_addr reads 0, and writes to it are ignored.
REQ-011 rdata SHALL be combinational from reg_addr. A write is visible to reads from the next cycle.
REQ-012 Status writable bits SHALL be IM[15:8], EXL[1] and IE[0]. BEV[22] SHALL read 1. All other Status bits SHALL read 0.
REQ-013 Cause SHALL hold BD[31], TI[30], IP[15:8] and ExcCode[6:2]. Only IP[9:8] is MTC0-writable. All other Cause bits SHALL read 0.
REQ-014 Cause IP[15:10] SHALL be registered each cycle:
- IP[10+i] = hw_int[i] for i < HW_INT_NUM, otherwise 0.
- IP[15] additionally ORs in TI.
REQ-015 Count SHALL advance by 1 every COUNT_DIV cycles using an internal phase counter, and SHALL wrap from 32'hFFFFFFFF to 0.
REQ-016 An MTC0 to Count SHALL load wdata, clear the phase counter, and override the increment that cycle.
REQ-017 TI SHALL set on the cycle Count increments to a value equal to Compare. It SHALL stay set until an MTC0 to Compare, which clears it. Clear wins over a same-cycle set.
REQ-018 int_pending SHALL equal |(Cause.IP & Status.IM) & Status.IE & ~Status.EXL, computed combinationally.
REQ-019 Commit priority when stall = 0 SHALL be: interrupt (int_pending) > exc_valid > eret. When stall = 1, nothing commits and flush = 0.
REQ-020 On an interrupt or exception commit:
- If EXL = 0 before the commit: EPC <= exc_pc and BD <= exc_bd.
- If EXL = 1: EPC and BD are unchanged.
- Always: EXL <= 1, and ExcCode <= 0 for an interrupt or exc_code for an exception.
- flush = 1 and flush_pc = EXC_VECTOR, both in the same cycle.
REQ-021 On an exception commit with exc_badv_we = 1, BadVAddr SHALL load exc_badvaddr. BadVAddr is unchanged on an interrupt commit.
REQ-022 On an ERET commit: EXL <= 0, flush = 1, flush_pc = EPC as it was before the edge.
REQ-023 wr_en SHALL be ignored in any cycle with an interrupt or exception commit, because the MTC0 is flushed.
REQ-024 wr_en with an ERET commit SHALL apply, except that an MTC0 to Status.EXL is overridden by ERET.
REQ-025 When nothing commits, flush_pc SHALL be 0 and flush SHALL be 0.
REQ-026 Count, the phase counter, TI and IP sampling SHALL continue while stall = 1.

Reset
REQ-027 When reset = 1 at a clock edge:
- Count, Compare, Cause, EPC, BadVAddr and the phase counter <= 0.
- Status <= 32'h00400000.
REQ-028 While reset = 1:
- rdata, flush, flush_pc and int_pending SHALL read 0.
- All inputs, including commits in progress, SHALL be ignored.

Verification
REQ-029 Timer: COUNT_DIV=2. Write Compare=5, Count=0 → timer_int rises on the edge where Count becomes 5 (10 cycles later).
- With Status=32'h00008001 → int_pending=1, flush=1, flush_pc=BFC00380, Cause.ExcCode=0, EXL=1.
- Then write Compare → TI=0.
REQ-030 Delay-slot exception: exc_valid=1, exc_code=5'h04, exc_bd=1, exc_pc=32'hBFC01004, exc_badv_we=1, exc_badvaddr=32'h00000003 → EPC=BFC01004, Cause=32'h80000010, BadVAddr=3, EXL=1.
REQ-031 Nested exception: repeat REQ-030's exception with EXL=1 and exc_pc=32'h1234 → EPC unchanged, ExcCode updated. ERET → flush_pc=BFC01004, EXL=0.
REQ-032 Priority:
- int_pending=1, exc_valid=1 and wr_en to EPC in one cycle → interrupt taken, ExcCode=0, EPC=exc_pc, MTC0 dropped.
- Same cycle with stall=1 → no state change, flush=0.
REQ-033 Wrap and width:
- Count=32'hFFFFFFFF, COUNT_DIV=1 → next value 0.
- HW_INT_NUM=2 with hw_int=2'b11 → Cause[15:8]=8'h0C.
- Assert reset mid-exception → all registers at reset values next cycle.
